context_switch_master: RTL and testbench
========================================

// Module: context_switch_master
// PURPOSE
//  Memory-side initiator for the per-process offset RAM. On a scheduler request it saves the
//  running process's context (PC + GPRs) into the context slots of its RAM window. It then
//  commits the new process base offset to the RAM and reloads PC + GPRs from the same slots
//  in the new window. Sits between scheduler, register file and RAM, and drives the RAM's
//  address/data/write and offset-change inputs during a switch.
// PARAMETERS
//  NREGS          32   context slots: slot 0 = PC, slots 1..NREGS-1 = GPR r1..r(NREGS-1)
//  CTX_BASE       12'hF00  window-relative address of slot 0 (RAM adds its active offset)
//  RD_LAT         1    cycles from mem_addr presented (mem_we=0) to mem_rdata valid, >=1
//  OFFSET_SETTLE  1    idle cycles after offset_change before first restore read, >=0
// PORTS
//  clk            in   1   single clock, all state on posedge
//  reset          in   1   asynchronous, active-high
//  start          in   1   request switch; sampled only in IDLE
//  new_offset     in   12  base offset of incoming process, latched with start
//  pc_in          in   32  PC of outgoing process
//  rf_rdata       in   32  register file read data (combinational from rf_raddr)
//  mem_rdata      in   32  RAM read data
//  busy           out  1   high from cycle after accepted start until done
//  done           out  1   one-cycle pulse at end of switch
//  cur_offset     out  12  last committed process offset
//  rf_raddr       out  5   register file read index
//  rf_waddr       out  5   register file write index
//  rf_wdata       out  32  register file write data
//  rf_we          out  1   register file write enable
//  pc_out         out  32  restored PC
//  pc_load        out  1   one-cycle strobe, pc_out valid
//  mem_addr       out  12  RAM address (window-relative)
//  mem_data       out  32  RAM write data
//  mem_we         out  1   RAM write enable
//  process_offset out  12  offset presented to RAM
//  offset_change  out  1   one-cycle strobe committing process_offset
// BEHAVIOUR
//  Reset: state=IDLE, slot counter=0, latched offset=0, cur_offset=0; every output 0.
//  Reset mid-switch aborts immediately: no further mem_we/rf_we/offset_change, no done.
//  States: IDLE -> SAVE -> SWITCH -> SETTLE -> RESTORE -> DONE -> IDLE.
//  IDLE: start=1 latches new_offset, k=0, go SAVE. start in any other state is ignored.
//  SAVE (NREGS cycles, k=0..NREGS-1): mem_we=1, mem_addr=CTX_BASE+k, rf_raddr=k,
//   mem_data = (k==0) ? pc_in : rf_rdata. Slot k == NREGS-1 -> SWITCH.
//  SWITCH (1 cycle): offset_change=1, process_offset=latched offset; cur_offset updates at the
//   edge ending this cycle. process_offset holds the latched value until IDLE, then returns to 0.
//  SETTLE (OFFSET_SETTLE cycles, skipped if 0): all strobes low.
//  RESTORE: per slot k, RD_LAT+1 cycles, mem_we=0, mem_addr=CTX_BASE+k held for whole slot.
//   In the last cycle of the slot (RD_LAT after the first), mem_rdata is consumed:
//   k==0 -> pc_out=mem_rdata registered, pc_load=1 next cycle; k>0 -> rf_we=1, rf_waddr=k,
//   rf_wdata=mem_rdata (combinational). rf_we is never asserted with rf_waddr=0.
//  DONE (1 cycle): done=1, busy=0; start is not accepted until back in IDLE.
//  Address arithmetic is modulo 2^12; CTX_BASE+k wrap is legal and not flagged.
//  new_offset equal to cur_offset is still a full switch (same window save/restore).
//  Latency, start accepted -> done: NREGS + 1 + OFFSET_SETTLE + NREGS*(RD_LAT+1) + 1 cycles
//   (defaults: 99). mem_we and offset_change are never high in the same cycle.
// TESTING
//  1 Reset, start=1 new_offset=12'h100 pc_in=32'h40 -> 32 mem_we cycles at 0xF00..0xF1F,
//    slot0 data 0x40; offset_change one cycle, process_offset=0x100; done at cycle 99.
//  2 Preload new window slots with 0xA0+k -> pc_load with pc_out=0xA0; rf_we k=1..31 with
//    data 0xA1..0xBF; no rf_we with rf_waddr=0.
//  3 Back-to-back switches 0x100 then 0x200 with start held high -> second accepted only after
//    done, starting in IDLE; cur_offset 0x100 then 0x200.
//  4 Assert reset in RESTORE at slot 5 -> all outputs 0 next cycle; no done or further rf_we;
//    cur_offset=0.
//  5 RD_LAT=3, OFFSET_SETTLE=0, NREGS=8 -> each restore slot lasts 4 cycles, rf_we in 4th;
//    done at 8+1+0+32+1=42.
//  6 CTX_BASE=12'hFFC, NREGS=8 -> save addresses FFC,FFD,FFE,FFF,000..003 (wrap).

Source files
------------

// File: rtl/context_switch_master.sv
// Context switch initiator: saves PC+GPRs into the outgoing process's RAM window,
// commits the new base offset, then reloads PC+GPRs from the incoming window.
module context_switch_master #(
  parameter int          NREGS         = 32,
  parameter logic [11:0] CTX_BASE      = 12'hF00,
  parameter int          RD_LAT        = 1,
  parameter int          OFFSET_SETTLE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [11:0] new_offset,
  input  logic [31:0] pc_in,
  input  logic [31:0] rf_rdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [11:0] cur_offset,
  output logic [4:0]  rf_raddr,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        rf_we,
  output logic [31:0] pc_out,
  output logic        pc_load,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        mem_we,
  output logic [11:0] process_offset,
  output logic        offset_change
);

  localparam int              KW      = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [KW-1:0]   K_LAST  = KW'(NREGS - 1);
  localparam int              PW      = $clog2(RD_LAT + 1) + 1;
  localparam logic [PW-1:0]   PH_LAST = PW'(RD_LAT);
  localparam int              SW      = $clog2(OFFSET_SETTLE + 1) + 1;
  localparam logic [SW-1:0]   S_LAST  = SW'((OFFSET_SETTLE > 0) ? OFFSET_SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_SWITCH,
    S_SETTLE,
    S_RESTORE,
    S_DONE
  } state_t;

  state_t        state, state_next;
  logic [KW-1:0] k;
  logic [PW-1:0] ph;
  logic [SW-1:0] sc;
  logic [11:0]   off_lat;
  logic [11:0]   slot_addr;
  logic [4:0]    slot_idx;
  logic          slot_end;

  assign slot_addr = CTX_BASE + 12'(k);
  assign slot_idx  = 5'(k);
  assign slot_end  = (ph == PH_LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_SAVE;
      S_SAVE:    if (k == K_LAST) state_next = S_SWITCH;
      S_SWITCH:  state_next = (OFFSET_SETTLE > 0) ? S_SETTLE : S_RESTORE;
      S_SETTLE:  if (sc == S_LAST) state_next = S_RESTORE;
      S_RESTORE: if (slot_end && (k == K_LAST)) state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Slot 0 of the context is the PC; the register file only ever sees slots 1..NREGS-1.
  always_comb begin
    busy           = 1'b0;
    done           = 1'b0;
    rf_raddr       = 5'd0;
    rf_waddr       = 5'd0;
    rf_wdata       = 32'd0;
    rf_we          = 1'b0;
    mem_addr       = 12'd0;
    mem_data       = 32'd0;
    mem_we         = 1'b0;
    process_offset = 12'd0;
    offset_change  = 1'b0;
    case (state)
      S_SAVE: begin
        busy     = 1'b1;
        mem_we   = 1'b1;
        mem_addr = slot_addr;
        rf_raddr = slot_idx;
        mem_data = (k == '0) ? pc_in : rf_rdata;
      end
      S_SWITCH: begin
        busy           = 1'b1;
        offset_change  = 1'b1;
        process_offset = off_lat;
      end
      S_SETTLE: begin
        busy           = 1'b1;
        process_offset = off_lat;
      end
      S_RESTORE: begin
        busy           = 1'b1;
        process_offset = off_lat;
        mem_addr       = slot_addr;
        if (slot_end && (slot_idx != 5'd0)) begin
          rf_we    = 1'b1;
          rf_waddr = slot_idx;
          rf_wdata = mem_rdata;
        end
      end
      S_DONE: begin
        done           = 1'b1;
        process_offset = off_lat;
      end
      default: ;
    endcase
  end

  // Slot counter k is shared by save and restore; it wraps to 0 at the end of each pass.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      k          <= '0;
      ph         <= '0;
      sc         <= '0;
      off_lat    <= 12'd0;
      cur_offset <= 12'd0;
      pc_out     <= 32'd0;
      pc_load    <= 1'b0;
    end else begin
      state   <= state_next;
      pc_load <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            off_lat <= new_offset;
            k       <= '0;
          end
        end
        S_SAVE: begin
          k  <= (k == K_LAST) ? '0 : k + KW'(1);
          ph <= '0;
          sc <= '0;
        end
        S_SWITCH: begin
          cur_offset <= off_lat;
          sc         <= '0;
          ph         <= '0;
        end
        S_SETTLE: sc <= sc + SW'(1);
        S_RESTORE: begin
          if (slot_end) begin
            ph <= '0;
            k  <= (k == K_LAST) ? '0 : k + KW'(1);
            if (k == '0) begin
              pc_out  <= mem_rdata;
              pc_load <= 1'b1;
            end
          end else begin
            ph <= ph + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_context_switch_master.sv
// Bench for context_switch_master: default instance (a_*) plus a small, slow-read,
// wrapping-window instance (b_*), each with its own RAM and register file models.
module tb_context_switch_master;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        a_start, a_busy, a_done, a_rf_we, a_pc_load, a_mem_we, a_offset_change;
  logic [11:0] a_new_offset, a_cur_offset, a_mem_addr, a_process_offset;
  logic [31:0] a_pc_in, a_rf_rdata, a_mem_rdata, a_rf_wdata, a_pc_out, a_mem_data;
  logic [4:0]  a_rf_raddr, a_rf_waddr;

  logic        b_start, b_busy, b_done, b_rf_we, b_pc_load, b_mem_we, b_offset_change;
  logic [11:0] b_new_offset, b_cur_offset, b_mem_addr, b_process_offset;
  logic [31:0] b_pc_in, b_rf_rdata, b_mem_rdata, b_rf_wdata, b_pc_out, b_mem_data;
  logic [4:0]  b_rf_raddr, b_rf_waddr;

  context_switch_master dut_a (
    .clk(clk), .reset(reset), .start(a_start), .new_offset(a_new_offset), .pc_in(a_pc_in),
    .rf_rdata(a_rf_rdata), .mem_rdata(a_mem_rdata), .busy(a_busy), .done(a_done),
    .cur_offset(a_cur_offset), .rf_raddr(a_rf_raddr), .rf_waddr(a_rf_waddr),
    .rf_wdata(a_rf_wdata), .rf_we(a_rf_we), .pc_out(a_pc_out), .pc_load(a_pc_load),
    .mem_addr(a_mem_addr), .mem_data(a_mem_data), .mem_we(a_mem_we),
    .process_offset(a_process_offset), .offset_change(a_offset_change)
  );

  context_switch_master #(.NREGS(8), .CTX_BASE(12'hFFC), .RD_LAT(3), .OFFSET_SETTLE(0)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .new_offset(b_new_offset), .pc_in(b_pc_in),
    .rf_rdata(b_rf_rdata), .mem_rdata(b_mem_rdata), .busy(b_busy), .done(b_done),
    .cur_offset(b_cur_offset), .rf_raddr(b_rf_raddr), .rf_waddr(b_rf_waddr),
    .rf_wdata(b_rf_wdata), .rf_we(b_rf_we), .pc_out(b_pc_out), .pc_load(b_pc_load),
    .mem_addr(b_mem_addr), .mem_data(b_mem_data), .mem_we(b_mem_we),
    .process_offset(b_process_offset), .offset_change(b_offset_change)
  );

  logic [147:0] a_outs, b_outs;
  assign a_outs = {a_busy, a_done, a_cur_offset, a_rf_raddr, a_rf_waddr, a_rf_wdata, a_rf_we,
                   a_pc_out, a_pc_load, a_mem_addr, a_mem_data, a_mem_we, a_process_offset,
                   a_offset_change};
  assign b_outs = {b_busy, b_done, b_cur_offset, b_rf_raddr, b_rf_waddr, b_rf_wdata, b_rf_we,
                   b_pc_out, b_pc_load, b_mem_addr, b_mem_data, b_mem_we, b_process_offset,
                   b_offset_change};

  // RAM models: physical address = active offset + window-relative address, modulo 4096.
  logic [31:0] a_ram [0:4095];
  logic [31:0] b_ram [0:4095];
  logic [11:0] a_ram_off, b_ram_off;
  logic [31:0] a_rd, b_rd0, b_rd1, b_rd2;
  logic        pre_we_a, pre_we_b, rf_init;
  logic [11:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] a_rf [0:31];
  logic [31:0] b_rf [0:31];

  assign a_mem_rdata = a_rd;
  assign b_mem_rdata = b_rd2;
  assign a_rf_rdata  = a_rf[a_rf_raddr];
  assign b_rf_rdata  = b_rf[b_rf_raddr];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      a_ram_off <= 12'd0;
      b_ram_off <= 12'd0;
    end else begin
      if (a_offset_change) a_ram_off <= a_process_offset;
      if (b_offset_change) b_ram_off <= b_process_offset;
    end
  end

  always @(posedge clk) begin
    if (pre_we_a) a_ram[pre_addr] <= pre_data;
    else if (a_mem_we) a_ram[a_ram_off + a_mem_addr] <= a_mem_data;
    if (pre_we_b) b_ram[pre_addr] <= pre_data;
    else if (b_mem_we) b_ram[b_ram_off + b_mem_addr] <= b_mem_data;
    a_rd  <= a_ram[a_ram_off + a_mem_addr];
    b_rd0 <= b_ram[b_ram_off + b_mem_addr];
    b_rd1 <= b_rd0;
    b_rd2 <= b_rd1;
  end

  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) begin
        a_rf[i] <= 32'h1000 + 32'(i);
        b_rf[i] <= 32'h2000 + 32'(i);
      end
    end else begin
      if (a_rf_we) a_rf[a_rf_waddr] <= a_rf_wdata;
      if (b_rf_we) b_rf[b_rf_waddr] <= b_rf_wdata;
    end
  end

  logic [43:0] exp_wr[$], obs_wr[$];
  logic [36:0] exp_rf[$], obs_rf[$];
  int oc_cnt, oc_cyc, overlap, rf0, pcl_cnt, done_cyc, busy_low, first_busy;
  logic [11:0] oc_val;
  logic [31:0] pcl_val;

  task automatic preload(input bit to_b, input logic [11:0] base, input logic [31:0] val0, input int cnt);
    for (int k = 0; k < cnt; k++) begin
      pre_addr = base + 12'(k);
      pre_data = val0 + 32'(k);
      pre_we_a = !to_b;
      pre_we_b = to_b;
      @(negedge clk);
    end
    pre_we_a = 1'b0;
    pre_we_b = 1'b0;
  endtask

  // Drives one switch on instance a and records what it produces; the callers judge it.
  task automatic run_a(input logic [11:0] off, input logic [31:0] pc, input bit hold);
    obs_wr.delete();
    obs_rf.delete();
    oc_cnt = 0; oc_cyc = -1; overlap = 0; rf0 = 0; pcl_cnt = 0; done_cyc = -1; busy_low = 0;
    oc_val = '0; pcl_val = '0;
    a_start = 1'b1;
    a_new_offset = off;
    a_pc_in = pc;
    @(posedge clk);
    #1;
    if (!hold) a_start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) first_busy = int'(a_busy);
      if (a_mem_we) obs_wr.push_back({a_mem_addr, a_mem_data});
      if (a_offset_change) begin oc_cnt++; oc_cyc = n; oc_val = a_process_offset; end
      if (a_mem_we && a_offset_change) overlap++;
      if (a_rf_we) obs_rf.push_back({a_rf_waddr, a_rf_wdata});
      if (a_rf_we && a_rf_waddr == 5'd0) rf0++;
      if (a_pc_load) begin pcl_cnt++; pcl_val = a_pc_out; end
      if (a_done) begin done_cyc = n; break; end
      if (!a_busy) busy_low++;
    end
  endtask

  task automatic test_reset();
    total++;
    if (a_outs !== '0) begin bad++; $display("[TB] FAIL reset_outputs_a: got %h expected 0", a_outs); end
    total++;
    if (b_outs !== '0) begin bad++; $display("[TB] FAIL reset_outputs_b: got %h expected 0", b_outs); end
  endtask

  task automatic test_save_restore();
    logic [43:0] e, o;
    logic [36:0] er, orf;
    preload(1'b0, 12'h000, 32'hA0, 32);
    for (int k = 0; k < 32; k++)
      exp_wr.push_back({12'hF00 + 12'(k), (k == 0) ? 32'h40 : 32'h1000 + 32'(k)});
    for (int k = 1; k < 32; k++) exp_rf.push_back({5'(k), 32'hA0 + 32'(k)});
    run_a(12'h100, 32'h40, 1'b0);
    total++;
    if (done_cyc !== 99) begin bad++; $display("[TB] FAIL done_latency: got %0d expected 99", done_cyc); end
    total++;
    if (oc_cnt !== 1 || oc_cyc !== 33 || oc_val !== 12'h100) begin
      bad++; $display("[TB] FAIL offset_change: got cnt=%0d cyc=%0d val=%h expected 1/33/100", oc_cnt, oc_cyc, oc_val);
    end
    total++;
    if (overlap !== 0) begin bad++; $display("[TB] FAIL we_oc_overlap: got %0d expected 0", overlap); end
    total++;
    if (busy_low !== 0) begin bad++; $display("[TB] FAIL busy_gap: got %0d expected 0", busy_low); end
    total++;
    if (obs_wr.size() !== exp_wr.size()) begin bad++; $display("[TB] FAIL save_count: got %0d expected %0d", obs_wr.size(), exp_wr.size()); end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL save_slot: got %h expected %h", o, e); end
    end
    exp_wr.delete();
    total++;
    if (obs_rf.size() !== exp_rf.size()) begin bad++; $display("[TB] FAIL restore_count: got %0d expected %0d", obs_rf.size(), exp_rf.size()); end
    while (exp_rf.size() > 0 && obs_rf.size() > 0) begin
      er = exp_rf.pop_front(); orf = obs_rf.pop_front();
      total++;
      if (orf !== er) begin bad++; $display("[TB] FAIL restore_slot: got %h expected %h", orf, er); end
    end
    exp_rf.delete();
    total++;
    if (rf0 !== 0) begin bad++; $display("[TB] FAIL rf_we_r0: got %0d expected 0", rf0); end
    total++;
    if (pcl_cnt !== 1 || pcl_val !== 32'hA0) begin
      bad++; $display("[TB] FAIL pc_restore: got cnt=%0d pc=%h expected 1/a0", pcl_cnt, pcl_val);
    end
    total++;
    if (a_cur_offset !== 12'h100) begin bad++; $display("[TB] FAIL cur_offset_1: got %h expected 100", a_cur_offset); end
  endtask

  task automatic test_back_to_back();
    logic [36:0] er, orf;
    logic [43:0] e, o;
    preload(1'b0, 12'h100, 32'hC0, 32);
    for (int k = 1; k < 32; k++) exp_rf.push_back({5'(k), 32'hA0 + 32'(k)});
    run_a(12'h100, 32'h50, 1'b1);
    total++;
    if (done_cyc !== 99 || pcl_val !== 32'h50) begin
      bad++; $display("[TB] FAIL same_window: got done=%0d pc=%h expected 99/50", done_cyc, pcl_val);
    end
    total++;
    if (obs_rf.size() !== exp_rf.size()) begin bad++; $display("[TB] FAIL same_window_count: got %0d expected %0d", obs_rf.size(), exp_rf.size()); end
    while (exp_rf.size() > 0 && obs_rf.size() > 0) begin
      er = exp_rf.pop_front(); orf = obs_rf.pop_front();
      total++;
      if (orf !== er) begin bad++; $display("[TB] FAIL same_window_slot: got %h expected %h", orf, er); end
    end
    exp_rf.delete();
    total++;
    if (a_cur_offset !== 12'h100) begin bad++; $display("[TB] FAIL cur_offset_b2b1: got %h expected 100", a_cur_offset); end
    a_new_offset = 12'h200;
    a_pc_in = 32'h60;
    @(negedge clk);
    total++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      bad++; $display("[TB] FAIL idle_gap: got busy=%b done=%b expected 0/0", a_busy, a_done);
    end
    for (int k = 0; k < 32; k++)
      exp_wr.push_back({12'hF00 + 12'(k), (k == 0) ? 32'h60 : 32'hA0 + 32'(k)});
    for (int k = 1; k < 32; k++) exp_rf.push_back({5'(k), 32'hC0 + 32'(k)});
    run_a(12'h200, 32'h60, 1'b0);
    total++;
    if (first_busy !== 1 || done_cyc !== 99) begin
      bad++; $display("[TB] FAIL second_accept: got busy1=%0d done=%0d expected 1/99", first_busy, done_cyc);
    end
    while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
      e = exp_wr.pop_front(); o = obs_wr.pop_front();
      total++;
      if (o !== e) begin bad++; $display("[TB] FAIL b2b_save: got %h expected %h", o, e); end
    end
    total++;
    if (exp_wr.size() !== 0 || obs_wr.size() !== 0) begin bad++; $display("[TB] FAIL b2b_save_count: left exp=%0d obs=%0d expected 0/0", exp_wr.size(), obs_wr.size()); end
    exp_wr.delete();
    while (exp_rf.size() > 0 && obs_rf.size() > 0) begin
      er = exp_rf.pop_front(); orf = obs_rf.pop_front();
      total++;
      if (orf !== er) begin bad++; $display("[TB] FAIL b2b_restore: got %h expected %h", orf, er); end
    end
    exp_rf.delete();
    total++;
    if (pcl_val !== 32'hC0 || a_cur_offset !== 12'h200) begin
      bad++; $display("[TB] FAIL b2b_final: got pc=%h cur=%h expected c0/200", pcl_val, a_cur_offset);
    end
  endtask

  task automatic test_reset_mid_restore();
    bit found;
    int late;
    found = 1'b0;
    late = 0;
    a_start = 1'b1;
    a_new_offset = 12'h300;
    a_pc_in = 32'h70;
    @(posedge clk);
    #1;
    a_start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (a_busy && !a_mem_we && a_mem_addr == 12'hF05) begin found = 1'b1; break; end
    end
    total++;
    if (!found) begin bad++; $display("[TB] FAIL reach_slot5: got 0 expected 1"); end
    reset = 1'b1;
    #1;
    total++;
    if (a_outs !== '0) begin bad++; $display("[TB] FAIL abort_outputs: got %h expected 0", a_outs); end
    @(negedge clk);
    total++;
    if (a_outs !== '0) begin bad++; $display("[TB] FAIL abort_outputs_next: got %h expected 0", a_outs); end
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (a_done || a_rf_we || a_mem_we || a_offset_change || a_pc_load) late++;
    end
    total++;
    if (late !== 0) begin bad++; $display("[TB] FAIL activity_after_abort: got %0d expected 0", late); end
    total++;
    if (a_cur_offset !== 12'h000) begin bad++; $display("[TB] FAIL cur_offset_abort: got %h expected 000", a_cur_offset); end
  endtask

  task automatic test_slow_read_wrap();
    logic [11:0] ew_addr[$], ow_addr[$];
    logic [31:0] ew_data[$], ow_data[$];
    int          er_cyc[$], or_cyc[$];
    logic [36:0] er_val[$], or_val[$];
    int bdone, bpcl_cyc;
    logic [31:0] bpcl_val;
    bdone = -1; bpcl_cyc = -1; bpcl_val = '0;
    preload(1'b1, 12'h03C, 32'hE0, 8);
    for (int k = 0; k < 8; k++) begin
      ew_addr.push_back(12'hFFC + 12'(k));
      ew_data.push_back((k == 0) ? 32'h77 : 32'h2000 + 32'(k));
    end
    for (int k = 1; k < 8; k++) begin
      er_cyc.push_back(13 + 4 * k);
      er_val.push_back({5'(k), 32'hE0 + 32'(k)});
    end
    b_start = 1'b1;
    b_new_offset = 12'h040;
    b_pc_in = 32'h77;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (b_mem_we) begin ow_addr.push_back(b_mem_addr); ow_data.push_back(b_mem_data); end
      if (b_rf_we) begin or_cyc.push_back(n); or_val.push_back({b_rf_waddr, b_rf_wdata}); end
      if (b_pc_load) begin bpcl_cyc = n; bpcl_val = b_pc_out; end
      if (b_done) begin bdone = n; break; end
    end
    total++;
    if (bdone !== 42) begin bad++; $display("[TB] FAIL slow_done_latency: got %0d expected 42", bdone); end
    total++;
    if (ow_addr.size() !== 8 || or_cyc.size() !== 7) begin
      bad++; $display("[TB] FAIL slow_counts: got wr=%0d rf=%0d expected 8/7", ow_addr.size(), or_cyc.size());
    end
    while (ew_addr.size() > 0 && ow_addr.size() > 0) begin
      logic [11:0] ea, oa;
      logic [31:0] ed, od;
      ea = ew_addr.pop_front(); oa = ow_addr.pop_front();
      ed = ew_data.pop_front(); od = ow_data.pop_front();
      total++;
      if (oa !== ea || od !== ed) begin bad++; $display("[TB] FAIL wrap_save: got %h/%h expected %h/%h", oa, od, ea, ed); end
    end
    while (er_cyc.size() > 0 && or_cyc.size() > 0) begin
      int ec, oc;
      logic [36:0] ev, ov;
      ec = er_cyc.pop_front(); oc = or_cyc.pop_front();
      ev = er_val.pop_front(); ov = or_val.pop_front();
      total++;
      if (oc !== ec || ov !== ev) begin bad++; $display("[TB] FAIL slow_restore: got cyc=%0d %h expected cyc=%0d %h", oc, ov, ec, ev); end
    end
    total++;
    if (bpcl_cyc !== 14 || bpcl_val !== 32'hE0) begin
      bad++; $display("[TB] FAIL slow_pc_load: got cyc=%0d pc=%h expected 14/e0", bpcl_cyc, bpcl_val);
    end
    total++;
    if (b_cur_offset !== 12'h040) begin bad++; $display("[TB] FAIL slow_cur_offset: got %h expected 040", b_cur_offset); end
  endtask

  initial begin
    reset = 1'b1;
    a_start = 1'b0; a_new_offset = '0; a_pc_in = '0;
    b_start = 1'b0; b_new_offset = '0; b_pc_in = '0;
    pre_we_a = 1'b0; pre_we_b = 1'b0; pre_addr = '0; pre_data = '0; rf_init = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    rf_init = 1'b1;
    @(negedge clk);
    rf_init = 1'b0;
    test_save_restore();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_reset_mid_restore();
    @(negedge clk);
    test_slow_read_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
